// File: rtl/pio_gpio_bidir.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear, synchronised inputs,
// edge capture with maskable level interrupt. Zero-wait-state combinational reads.
module pio_gpio_bidir #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET  = '0,
  parameter logic [WIDTH-1:0] DIR_RESET  = '0,
  parameter int              EDGE_TYPE   = 0,
  parameter int              SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int              CNT_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] ARM_CNT = CNT_W'(SYNC_STAGES + 1);

  typedef enum logic {WARM, ARMED} arm_state_e;

  arm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] cap_clr;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_set;

  logic             wr_en;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdat         = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Arming: hold off edge detection until the synchroniser and in_prev
  // have been filled with real pin samples after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WARM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed   = 1'b0;
    case (state_q)
      WARM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ARM_CNT - CNT_W'(1)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        armed = 1'b1;
      end
      default: begin
        state_d = WARM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= in_sync;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_raw = in_sync & ~prev_q;
      1:       edge_raw = ~in_sync & prev_q;
      default: edge_raw = in_sync ^ prev_q;
    endcase
  end

  assign edge_set = edge_raw & ~dir_q & {WIDTH{armed}};

  always_comb begin
    out_d   = out_q;
    dir_d   = dir_q;
    mask_d  = mask_q;
    cap_clr = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d   = wdat;
        ADDR_DIR:     dir_d   = wdat;
        ADDR_IRQMASK: mask_d  = wdat;
        ADDR_EDGECAP: cap_clr = wdat;
        ADDR_OUTSET:  out_d   = out_q | wdat;
        ADDR_OUTCLR:  out_d   = out_q & ~wdat;
        default:      ;
      endcase
    end
    // A new edge beats a simultaneous clear so no event is ever lost.
    cap_d = (cap_q & ~cap_clr) | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= OUT_RESET;
      dir_q  <= DIR_RESET;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (dir_q & out_q) | (~dir_q & in_sync);
      ADDR_DIR:     rd_val = dir_q;
      ADDR_IRQMASK: rd_val = mask_q;
      ADDR_EDGECAP: rd_val = cap_q;
      default:      rd_val = '0;
    endcase
  end

  assign readdata = 32'(rd_val);
  assign out_port = out_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_gpio_bidir.sv
// Bench for pio_gpio_bidir: pin-history reference model checked every cycle,
// plus directed literal checks of reset, set/clear, sync latency and edge capture.
module tb_pio_gpio_bidir;
  localparam int W  = 8;
  localparam int SS = 2;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [31:0] readdata;
  logic [W-1:0] in_port   = '0;
  logic [W-1:0] out_port;
  logic [W-1:0] oe;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pio_gpio_bidir #(
    .WIDTH(W), .OUT_RESET(8'hA5), .DIR_RESET(8'h0F), .EDGE_TYPE(0), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: registers plus a history of pin samples (index 0 = latest edge).
  logic [7:0] m_out  = 8'hA5;
  logic [7:0] m_dir  = 8'h0F;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_cap  = 8'h00;
  logic [7:0] hist[$];
  int         m_cyc  = 0;
  logic [7:0] ms, mp, mev, mclr, mwd;

  function automatic logic [7:0] hsample(int n);
    if (n < hist.size()) return hist[n];
    return 8'h00;
  endfunction

  function automatic logic [31:0] m_rd(logic [2:0] a);
    logic [7:0] v;
    case (a)
      3'd0:    v = (m_dir & m_out) | (~m_dir & hsample(SS-1));
      3'd1:    v = m_dir;
      3'd2:    v = m_mask;
      3'd3:    v = m_cap;
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out = 8'hA5; m_dir = 8'h0F; m_mask = 8'h00; m_cap = 8'h00;
      hist.delete();
      m_cyc = 0;
    end else begin
      ms  = hsample(SS-1);
      mp  = hsample(SS);
      mev = ms & ~mp & ~m_dir;
      if (m_cyc < SS + 1) mev = 8'h00;
      mclr = 8'h00;
      if (chipselect && !write_n) begin
        mwd = writedata[7:0];
        case (address)
          3'd0: m_out = mwd;
          3'd1: m_dir = mwd;
          3'd2: m_mask = mwd;
          3'd3: mclr = mwd;
          3'd4: m_out = m_out | mwd;
          3'd5: m_out = m_out & ~mwd;
          default: ;
        endcase
      end
      m_cap = (m_cap & ~mclr) | mev;
      hist.push_front(in_port);
      if (hist.size() > 8) void'(hist.pop_back());
      if (m_cyc < 100) m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("cyc_out_port", {24'h0, out_port}, {24'h0, m_out});
    check("cyc_oe", {24'h0, oe}, {24'h0, m_dir});
    check("cyc_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
    check("cyc_readdata", readdata, m_rd(address));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
  endtask

  task automatic idle();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic peek(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    repeat (3) step();
    check("rst_out_port", {24'h0, out_port}, 32'hA5);
    check("rst_oe", {24'h0, oe}, 32'h0F);
    check("rst_irq", {31'h0, irq}, 32'h0);
    peek(3'd1);
    check("rst_rd_dir", readdata, 32'h0000000F);
    reset_n = 1'b1;
    repeat (5) step();

    wr(3'd0, 32'hFFFF_FF3C); check("data_write", {24'h0, out_port}, 32'h3C);
    wr(3'd4, 32'h0000_0081); check("outset", {24'h0, out_port}, 32'hBD);
    wr(3'd5, 32'h0000_0004); check("outclr", {24'h0, out_port}, 32'hB9);
    idle();

    wr(3'd0, 32'hFF); idle();
    in_port = 8'h50;
    repeat (3) step();
    peek(3'd0); check("data_read_mix", readdata, 32'h0000005F);
    peek(3'd3); check("cap_mix", readdata, 32'h00000050);
    peek(3'd4); check("outset_reads_zero", readdata, 32'h0);

    wr(3'd3, 32'hFF); idle();
    in_port = 8'h00;
    repeat (4) step();
    peek(3'd3); check("cap_cleared", readdata, 32'h0);

    wr(3'd2, 32'h10); idle();
    in_port = 8'h10;
    step();
    step(); check("irq_before_sync", {31'h0, irq}, 32'h0);
    step(); check("irq_set", {31'h0, irq}, 32'h1);
    peek(3'd3); check("cap_bit4", readdata, 32'h10);
    wr(3'd3, 32'h10); idle();
    check("irq_cleared", {31'h0, irq}, 32'h0);

    in_port = 8'h00; repeat (3) step();
    in_port = 8'h10; repeat (3) step();
    check("irq_reset_pre", {31'h0, irq}, 32'h1);
    in_port = 8'h00; repeat (3) step();
    in_port = 8'h10; step(); step();
    wr(3'd3, 32'h10); idle();
    check("clr_vs_set_irq", {31'h0, irq}, 32'h1);
    peek(3'd3); check("clr_vs_set_cap", readdata, 32'h10);

    wr(3'd3, 32'hFF); wr(3'd1, 32'h3F); idle();
    in_port = 8'h30;
    repeat (3) step();
    peek(3'd3); check("dir_out_no_cap", readdata, 32'h0);

    wr(3'd1, 32'h0F); idle();
    in_port = 8'h00; repeat (3) step();
    in_port = 8'h10; repeat (3) step();
    check("pre_rst_irq", {31'h0, irq}, 32'h1);
    address = 3'd3;
    in_port = 8'hFF;
    reset_n = 1'b0;
    #1;
    check("rst_async_cap", readdata, 32'h0);
    check("rst_async_irq", {31'h0, irq}, 32'h0);
    check("rst_async_out", {24'h0, out_port}, 32'hA5);
    repeat (2) step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("warm_no_cap", readdata, 32'h0);
    end

    wr(3'd6, 32'hFF); wr(3'd7, 32'hFF); wr(3'd2, 32'hFF); idle();
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      step();
    end
    peek(3'd7); check("addr7_reads_zero", readdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
